croc_gpio_padctrl: RTL

Parametrised GPIO pad controller between the SoC GPIO peripheral and the `sg13g2_IOPadInOut30mA` pad ring. Per channel:
- synchronises and optionally debounces the pad input;
- detects rising and falling edges into sticky interrupt flags;
- drives the pad in one of four output modes (input, push-pull, open-drain, open-source).

It replaces direct wiring of `gpio_o`/`gpio_out_en_o`/`gpio_i` to the pads.

---
 rtl/gpio_pad_pkg.sv | 20 ++
 rtl/gpio_in_filter.sv | 62 ++++++
 rtl/croc_gpio_padctrl.sv | 124 ++++++++++++
 3 files changed

// File: rtl/gpio_pad_pkg.sv
// Shared types and default parameters for the GPIO pad controller.
package gpio_pad_pkg;

    localparam int unsigned DefNumGpio    = 32;
    localparam int unsigned DefSyncStages = 2;
    localparam int unsigned DefFiltWidth  = 4;

    typedef enum logic [1:0] {
        GPIO_INPUT      = 2'd0,
        GPIO_PUSHPULL   = 2'd1,
        GPIO_OPENDRAIN  = 2'd2,
        GPIO_OPENSOURCE = 2'd3
    } gpio_mode_e;

    typedef enum logic {
        ARM_ST = 1'b0,
        RUN_ST = 1'b1
    } arm_state_e;

endpackage

// File: rtl/gpio_in_filter.sv
// One GPIO input channel: synchroniser, debounce counter and stable value.
// stable_o is the value stable takes at the next edge; stable_q_o is the current one.
module gpio_in_filter
    import gpio_pad_pkg::*;
#(
    parameter int unsigned SyncStages = DefSyncStages,
    parameter int unsigned FiltWidth  = DefFiltWidth
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 arm_i,
    input  logic                 filt_en_i,
    input  logic [FiltWidth-1:0] filt_len_i,
    input  logic                 pad_i,
    output logic                 stable_o,
    output logic                 stable_q_o
);

    logic [SyncStages-1:0] sync_q;
    logic                  sync;
    logic                  stable_q, stable_d;
    logic [FiltWidth-1:0]  cnt_q, cnt_d;
    logic [FiltWidth-1:0]  len_m1;

    assign sync = sync_q[SyncStages-1];

    // A length of 0 behaves as 1; >= keeps a shortened length from stalling the counter.
    always_comb begin
        stable_d = stable_q;
        cnt_d    = cnt_q;
        len_m1   = (filt_len_i == '0) ? '0 : filt_len_i - FiltWidth'(1);
        if (arm_i) begin
            stable_d = sync;
            cnt_d    = '0;
        end else if (!filt_en_i) begin
            stable_d = sync;
        end else if (sync == stable_q) begin
            cnt_d = '0;
        end else if (cnt_q >= len_m1) begin
            stable_d = sync;
            cnt_d    = '0;
        end else begin
            cnt_d = cnt_q + FiltWidth'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync_q   <= '0;
            stable_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            sync_q   <= {sync_q[SyncStages-2:0], pad_i};
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
        end
    end

    assign stable_o   = stable_d;
    assign stable_q_o = stable_q;

endmodule

// File: rtl/croc_gpio_padctrl.sv
// GPIO pad controller: filtered inputs, sticky edge interrupts and pad output modes.
module croc_gpio_padctrl
    import gpio_pad_pkg::*;
#(
    parameter int unsigned NumGpio    = DefNumGpio,
    parameter int unsigned SyncStages = DefSyncStages,
    parameter int unsigned FiltWidth  = DefFiltWidth
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic [2*NumGpio-1:0]   mode_i,
    input  logic [NumGpio-1:0]     filt_en_i,
    input  logic [FiltWidth-1:0]   filt_len_i,
    input  logic [NumGpio-1:0]     rise_en_i,
    input  logic [NumGpio-1:0]     fall_en_i,
    input  logic [NumGpio-1:0]     irq_clr_i,
    input  logic [NumGpio-1:0]     gpio_out_i,
    output logic [NumGpio-1:0]     gpio_in_o,
    output logic [NumGpio-1:0]     irq_pend_o,
    output logic                   irq_o,
    output logic [NumGpio-1:0]     pad_c2p_o,
    output logic [NumGpio-1:0]     pad_c2p_en_o,
    input  logic [NumGpio-1:0]     pad_p2c_i
);

    localparam int unsigned ArmW = $clog2(SyncStages + 2);

    arm_state_e         state_q, state_d;
    logic [ArmW-1:0]    arm_cnt_q, arm_cnt_d;
    logic               arm;
    logic [NumGpio-1:0] stable_nxt, stable_cur;
    logic [NumGpio-1:0] set_c;
    logic [NumGpio-1:0] pend_q, pend_d;
    logic [NumGpio-1:0] c2p_q, c2p_d, en_q, en_d;

    // Hold off edge detection until the synchronisers carry real pad values.
    always_comb begin
        state_d   = state_q;
        arm_cnt_d = arm_cnt_q;
        if (state_q == ARM_ST) begin
            if (arm_cnt_q == ArmW'(SyncStages)) begin
                state_d = RUN_ST;
            end else begin
                arm_cnt_d = arm_cnt_q + ArmW'(1);
            end
        end
    end

    assign arm = (state_q == ARM_ST);

    for (genvar g = 0; g < NumGpio; g++) begin : g_chan
        gpio_in_filter #(
            .SyncStages (SyncStages),
            .FiltWidth  (FiltWidth)
        ) u_filt (
            .clk_i      (clk_i),
            .rst_i      (rst_i),
            .arm_i      (arm),
            .filt_en_i  (filt_en_i[g]),
            .filt_len_i (filt_len_i),
            .pad_i      (pad_p2c_i[g]),
            .stable_o   (stable_nxt[g]),
            .stable_q_o (stable_cur[g])
        );
    end

    // Set has priority over clear so an edge is never lost.
    always_comb begin
        set_c = '0;
        if (!arm) begin
            set_c = (stable_nxt & ~stable_cur & rise_en_i)
                  | (~stable_nxt & stable_cur & fall_en_i);
        end
        pend_d = set_c | (pend_q & ~irq_clr_i);
    end

    always_comb begin
        c2p_d = '0;
        en_d  = '0;
        for (int unsigned i = 0; i < NumGpio; i++) begin
            case (gpio_mode_e'(mode_i[2*i +: 2]))
                GPIO_INPUT: begin
                    en_d[i]  = 1'b0;
                    c2p_d[i] = 1'b0;
                end
                GPIO_PUSHPULL: begin
                    en_d[i]  = 1'b1;
                    c2p_d[i] = gpio_out_i[i];
                end
                GPIO_OPENDRAIN: begin
                    en_d[i]  = ~gpio_out_i[i];
                    c2p_d[i] = 1'b0;
                end
                GPIO_OPENSOURCE: begin
                    en_d[i]  = gpio_out_i[i];
                    c2p_d[i] = 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= ARM_ST;
            arm_cnt_q <= '0;
            pend_q    <= '0;
            c2p_q     <= '0;
            en_q      <= '0;
        end else begin
            state_q   <= state_d;
            arm_cnt_q <= arm_cnt_d;
            pend_q    <= pend_d;
            c2p_q     <= c2p_d;
            en_q      <= en_d;
        end
    end

    assign gpio_in_o    = stable_cur;
    assign irq_pend_o   = pend_q;
    assign irq_o        = |pend_q;
    assign pad_c2p_o    = c2p_q;
    assign pad_c2p_en_o = en_q;

endmodule
